// File: rtl/stall_sequencer.sv
// D/X-boundary stall control: load-use hazard detection, mult/div start/freeze/release
// sequencing with timeout, and a saturating stall-cycle performance counter.
module stall_sequencer #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR_FD,
  input  logic [31:0] IR_DX,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_dx,
  output logic        bubble_xm,
  output logic        md_take,
  output logic        md_error,
  output logic        md_busy,
  output logic [31:0] perf_stall_cnt
);

  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        state, state_next;
  logic [CNT_W-1:0] md_count, md_count_next;

  logic [4:0] op_fd, rs_fd, rt_fd;
  logic [4:0] op_dx, rd_dx, alu_dx;
  logic       md_in_dx, fd_reads_rs, fd_reads_rt, load_use, freeze;
  logic       unused_ir;

  assign op_fd  = IR_FD[31:27];
  assign rs_fd  = IR_FD[21:17];
  assign rt_fd  = IR_FD[16:12];
  assign op_dx  = IR_DX[31:27];
  assign rd_dx  = IR_DX[26:22];
  assign alu_dx = IR_DX[6:2];
  assign unused_ir = ^{IR_FD[26:22], IR_FD[11:0], IR_DX[21:7], IR_DX[1:0]};

  assign md_in_dx = (op_dx == OP_RTYPE) && ((alu_dx == ALU_MUL) || (alu_dx == ALU_DIV));

  // Only consumers that need the loaded value in X stall; branches and sw data use the memory bypass.
  assign fd_reads_rs = (op_fd == OP_RTYPE) || (op_fd == OP_ADDI) ||
                       (op_fd == OP_SW)    || (op_fd == OP_LW);
  assign fd_reads_rt = (op_fd == OP_RTYPE);
  assign load_use = (op_dx == OP_LW) && (rd_dx != 5'd0) &&
                    ((fd_reads_rs && (rs_fd == rd_dx)) || (fd_reads_rt && (rt_fd == rd_dx)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      md_count <= '0;
    end else begin
      state    <= state_next;
      md_count <= md_count_next;
    end
  end

  // The release cycle drops the freeze so the mul/div in D/X advances with its result.
  always_comb begin
    state_next    = state;
    md_count_next = md_count;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    md_take       = 1'b0;
    md_error      = 1'b0;
    md_busy       = 1'b0;
    freeze        = 1'b0;
    case (state)
      IDLE: begin
        if (md_in_dx) begin
          ctrl_MULT     = (alu_dx == ALU_MUL);
          ctrl_DIV      = (alu_dx == ALU_DIV);
          freeze        = 1'b1;
          md_count_next = CNT_W'(1);
          state_next    = BUSY;
        end
      end
      BUSY: begin
        md_busy = 1'b1;
        if (md_resultRDY) begin
          md_take    = 1'b1;
          md_error   = md_exception;
          state_next = IDLE;
        end else if (md_count == CNT_W'(MD_TIMEOUT)) begin
          md_take    = 1'b1;
          md_error   = 1'b1;
          state_next = IDLE;
        end else begin
          freeze        = 1'b1;
          md_count_next = md_count + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bubble_dx = load_use && (state == IDLE) && !freeze;
    stall_pc  = freeze || bubble_dx;
    stall_fd  = freeze || bubble_dx;
    stall_dx  = freeze;
    bubble_xm = freeze;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cnt <= '0;
    end else if (stall_pc && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_stall_sequencer.sv
// Directed bench for stall_sequencer: per-cycle expected outputs go through a scoreboard queue
// and are compared on the falling edge with immediate assertions.
module tb_stall_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IR_FD = '0;
  logic [31:0] IR_DX = '0;
  logic        md_resultRDY = 1'b0;
  logic        md_exception = 1'b0;
  logic        ctrl_MULT, ctrl_DIV, stall_pc, stall_fd, stall_dx;
  logic        bubble_dx, bubble_xm, md_take, md_error, md_busy;
  logic [31:0] perf_stall_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [31:0] exp_perf = '0;

  typedef struct {
    string       tag;
    logic [9:0]  outs;
    logic [31:0] perf;
  } exp_t;
  exp_t sb[$];

  // {ctrl_MULT, ctrl_DIV, stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, md_take, md_error, md_busy}
  localparam logic [9:0] NONE     = 10'b0000000000;
  localparam logic [9:0] LU       = 10'b0011010000;
  localparam logic [9:0] START_M  = 10'b1011101000;
  localparam logic [9:0] START_D  = 10'b0111101000;
  localparam logic [9:0] BUSY_F   = 10'b0011101001;
  localparam logic [9:0] TAKE_OK  = 10'b0000000101;
  localparam logic [9:0] TAKE_ERR = 10'b0000000111;

  stall_sequencer #(.MD_TIMEOUT(40)) dut (
    .clock          (clock),
    .reset          (reset),
    .IR_FD          (IR_FD),
    .IR_DX          (IR_DX),
    .md_resultRDY   (md_resultRDY),
    .md_exception   (md_exception),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .stall_pc       (stall_pc),
    .stall_fd       (stall_fd),
    .stall_dx       (stall_dx),
    .bubble_dx      (bubble_dx),
    .bubble_xm      (bubble_xm),
    .md_take        (md_take),
    .md_error       (md_error),
    .md_busy        (md_busy),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] r_ins(input logic [4:0] alu, rd, rs, rt);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic applyStimulus(input string tag, input logic rst, input logic [31:0] fd, dx,
                               input logic rdy, exc, input logic [9:0] exp_outs);
    exp_t e;
    @(posedge clock);
    #1;
    reset        = rst;
    IR_FD        = fd;
    IR_DX        = dx;
    md_resultRDY = rdy;
    md_exception = exc;
    e.tag  = tag;
    e.outs = exp_outs;
    e.perf = exp_perf;
    sb.push_back(e);
    if (rst) exp_perf = '0;
    else if (exp_outs[7] && exp_perf != 32'hFFFF_FFFF) exp_perf = exp_perf + 32'd1;
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [9:0] obs;
    @(negedge clock);
    e   = sb.pop_front();
    obs = {ctrl_MULT, ctrl_DIV, stall_pc, stall_fd, stall_dx,
           bubble_dx, bubble_xm, md_take, md_error, md_busy};
    n_compared++;
    assert (obs === e.outs) else begin
      n_mismatched++;
      $error("[TB] FAIL %s outs: observed=%b expected=%b", e.tag, obs, e.outs);
    end
    n_compared++;
    assert (perf_stall_cnt === e.perf) else begin
      n_mismatched++;
      $error("[TB] FAIL %s perf: observed=%0d expected=%0d", e.tag, perf_stall_cnt, e.perf);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [31:0] fd, dx,
                      input logic rdy, exc, input logic [9:0] exp_outs);
    applyStimulus(tag, rst, fd, dx, rdy, exc, exp_outs);
    checkOutput();
  endtask

  initial begin
    logic [31:0] nop, lw5, lw0, mul, mul2, dv;
    nop  = '0;
    lw5  = i_ins(5'b01000, 5'd5, 5'd2, 17'd0);
    lw0  = i_ins(5'b01000, 5'd0, 5'd2, 17'd0);
    mul  = r_ins(5'b00110, 5'd9, 5'd4, 5'd5);
    mul2 = r_ins(5'b00110, 5'd10, 5'd9, 5'd6);
    dv   = r_ins(5'b00111, 5'd11, 5'd4, 5'd0);

    step("reset0", 1'b1, nop, nop, 1'b0, 1'b0, NONE);
    step("reset1", 1'b1, nop, nop, 1'b0, 1'b0, NONE);
    step("idle",   1'b0, nop, nop, 1'b0, 1'b0, NONE);

    step("lu_rs",       1'b0, r_ins(5'b00000, 5'd7, 5'd5, 5'd3), lw5, 1'b0, 1'b0, LU);
    step("lu_rs_after", 1'b0, r_ins(5'b00000, 5'd7, 5'd5, 5'd3), nop, 1'b0, 1'b0, NONE);
    step("lu_rt",       1'b0, r_ins(5'b00000, 5'd7, 5'd3, 5'd5), lw5, 1'b0, 1'b0, LU);
    step("lu_rt_after", 1'b0, r_ins(5'b00000, 5'd7, 5'd3, 5'd5), nop, 1'b0, 1'b0, NONE);
    step("lu_addi",     1'b0, i_ins(5'b00101, 5'd7, 5'd5, 17'd1), lw5, 1'b0, 1'b0, LU);
    step("lu_lw_base",  1'b0, i_ins(5'b01000, 5'd8, 5'd5, 17'd4), lw5, 1'b0, 1'b0, LU);
    step("lu_sw_base",  1'b0, i_ins(5'b00111, 5'd6, 5'd5, 17'd0), lw5, 1'b0, 1'b0, LU);
    step("no_lu_r0",    1'b0, r_ins(5'b00000, 5'd7, 5'd0, 5'd3), lw0, 1'b0, 1'b0, NONE);
    step("no_lu_bne",   1'b0, i_ins(5'b00010, 5'd5, 5'd6, 17'd3), lw5, 1'b0, 1'b0, NONE);
    step("no_lu_swdat", 1'b0, i_ins(5'b00111, 5'd5, 5'd2, 17'd0), lw5, 1'b0, 1'b0, NONE);
    step("no_lu_addirt",1'b0, i_ins(5'b00101, 5'd7, 5'd3, 17'h05000), lw5, 1'b0, 1'b0, NONE);

    // Multiply completing at T+33; md_exception pulses without RDY must be ignored.
    step("mul_start", 1'b0, nop, mul, 1'b0, 1'b0, START_M);
    for (int k = 1; k <= 32; k++)
      step($sformatf("mul_busy%0d", k), 1'b0, nop, mul, 1'b0, (k % 7 == 0), BUSY_F);
    step("mul_take",    1'b0, nop, mul, 1'b1, 1'b0, TAKE_OK);
    step("mul_idle",    1'b0, nop, nop, 1'b0, 1'b0, NONE);
    step("idle_rdy_ign",1'b0, nop, nop, 1'b1, 1'b1, NONE);

    step("div_start", 1'b0, nop, dv, 1'b0, 1'b0, START_D);
    for (int k = 1; k <= 4; k++)
      step($sformatf("div_busy%0d", k), 1'b0, nop, dv, 1'b0, 1'b0, BUSY_F);
    step("div_exc_take", 1'b0, nop, dv, 1'b1, 1'b1, TAKE_ERR);
    step("div_idle",     1'b0, nop, nop, 1'b0, 1'b0, NONE);

    step("to_start", 1'b0, nop, dv, 1'b0, 1'b0, START_D);
    for (int k = 1; k <= 39; k++)
      step($sformatf("to_busy%0d", k), 1'b0, nop, dv, 1'b0, 1'b0, BUSY_F);
    step("to_take", 1'b0, nop, dv, 1'b0, 1'b0, TAKE_ERR);
    step("to_idle", 1'b0, nop, nop, 1'b0, 1'b0, NONE);

    // RDY in the timeout cycle takes precedence over the timeout error.
    step("torace_start", 1'b0, nop, dv, 1'b0, 1'b0, START_D);
    for (int k = 1; k <= 39; k++)
      step($sformatf("torace_busy%0d", k), 1'b0, nop, dv, 1'b0, 1'b0, BUSY_F);
    step("torace_take", 1'b0, nop, dv, 1'b1, 1'b0, TAKE_OK);
    step("torace_idle", 1'b0, nop, nop, 1'b0, 1'b0, NONE);

    step("rst_start", 1'b0, nop, mul, 1'b0, 1'b0, START_M);
    for (int k = 1; k <= 9; k++)
      step($sformatf("rst_busy%0d", k), 1'b0, nop, mul, 1'b0, 1'b0, BUSY_F);
    step("rst_mid_busy", 1'b1, nop, mul, 1'b0, 1'b0, BUSY_F);
    step("rst_after",    1'b0, nop, nop, 1'b1, 1'b0, NONE);
    step("rst_after2",   1'b0, nop, nop, 1'b0, 1'b0, NONE);

    step("b2b_start1", 1'b0, nop, mul, 1'b0, 1'b0, START_M);
    step("b2b_busy1a", 1'b0, nop, mul, 1'b0, 1'b0, BUSY_F);
    step("b2b_busy1b", 1'b0, nop, mul, 1'b0, 1'b0, BUSY_F);
    step("b2b_take1",  1'b0, nop, mul, 1'b1, 1'b0, TAKE_OK);
    step("b2b_start2", 1'b0, nop, mul2, 1'b0, 1'b0, START_M);
    step("b2b_busy2",  1'b0, nop, mul2, 1'b0, 1'b0, BUSY_F);
    step("b2b_take2",  1'b0, nop, mul2, 1'b1, 1'b0, TAKE_OK);
    step("b2b_idle",   1'b0, nop, nop, 1'b0, 1'b0, NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/stall_sequencer.md
# stall_sequencer

Pipeline stall and multi-cycle-unit sequencer. Sits beside the bypass unit in the D/X boundary logic: detects load-use hazards the bypass network cannot cover, issues start pulses to the mult/div unit, freezes the front of the pipeline while that unit runs, and releases the result into the X/M latch. Also keeps a saturating stall-cycle performance counter.

## Interface
- MD_TIMEOUT, 40, max BUSY cycles before the mult/div op is aborted with an error (≥2)
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- IR_FD  in  32  instruction in F/D latch
- IR_DX  in  32  instruction in D/X latch
- md_resultRDY  in  1  mult/div result valid (level, sampled only in BUSY)
- md_exception  in  1  mult/div overflow/div-by-zero, valid with md_resultRDY
- ctrl_MULT  out  1  one-cycle start pulse to mult/div, multiply
- ctrl_DIV  out  1  one-cycle start pulse to mult/div, divide
- stall_pc  out  1  hold PC
- stall_fd  out  1  hold F/D latch
- stall_dx  out  1  hold D/X latch
- bubble_dx  out  1  load nop into D/X (overrides stall_dx)
- bubble_xm  out  1  load nop into X/M
- md_take  out  1  X/M captures mult/div result instead of ALU output
- md_error  out  1  with md_take: write rstatus (exception or timeout)
- md_busy  out  1  state ≠ IDLE
- perf_stall_cnt  out  32  count of cycles with stall_pc=1, saturates at 32'hFFFFFFFF

## Operation
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALUop [6:2].
- md_in_dx: IR_DX opcode 00000 and ALUop 00110 (mul) or 00111 (div).
- Load-use (combinational): IR_DX opcode 01000 (lw), rd_DX ≠ 0, and IR_FD reads rd_DX as:
  - rs, for opcodes 00000, 00101 (addi), 00111 (sw base), 01000 (lw)
  - rt, for opcode 00000 only
- bne/blt/jr/sw-data consumers never stall; they are covered by the memory bypass path.
- Load-use response, one cycle: stall_pc=stall_fd=bubble_dx=1.
- Mult/div FSM, states IDLE, BUSY:
  - IDLE & md_in_dx: ctrl_MULT or ctrl_DIV =1 per ALUop (combinational); counter←1; →BUSY.
  - BUSY & md_resultRDY: md_take=1, md_error=md_exception; →IDLE.
  - BUSY & !RDY & counter==MD_TIMEOUT: md_take=1, md_error=1; →IDLE.
  - BUSY otherwise: counter←counter+1.
- Mult/div freeze: asserted in IDLE with md_in_dx, and in BUSY except the release cycle. Freeze means stall_pc=stall_fd=stall_dx=1 and bubble_xm=1.
- Release cycle (md_take=1): all stalls and bubble_xm are 0, so the mul/div in D/X advances.
- md_resultRDY is ignored in IDLE.
- md_exception is ignored without RDY.
- Priority: mult/div freeze over load-use. The two cannot coexist: lw and mul/div are never both in D/X.
- perf_stall_cnt increments every cycle stall_pc=1, until saturation.

## Timing
- Reset: state IDLE, counter 0, perf_stall_cnt 0. Every registered-dependent output is 0 in the cycle after reset is sampled high.
- Outputs stay combinational from IR_FD/IR_DX inputs.
- Reset mid-BUSY: IDLE next cycle, no md_take, no further pulse.
- Start pulse: ctrl_* high exactly one cycle (cycle T); BUSY from T+1.
- RDY at T+k (k≥1): md_take at T+k; IDLE at T+k+1.
- New IR_DX at T+k+1: a back-to-back mul/div starts at T+k+1 with no gap cycle.
- Total freeze for a mul/div completing at T+k: k cycles (T..T+k-1).
- Timeout: counter==MD_TIMEOUT in cycle T+MD_TIMEOUT; md_take/md_error asserted there.
- RDY arriving in that same cycle wins: md_error=md_exception.
- Load-use: exactly one stall cycle. Next cycle lw is in X/M, bubble in D/X, no re-detection.

## Test plan
- Load-use: IR_DX=lw $5,0($2), IR_FD=add $7,$5,$3 -> stall_pc=stall_fd=bubble_dx=1 for 1 cycle. Same with add $7,$3,$5 (rt) -> stall. perf_stall_cnt=1.
- No false stall: lw to $0 followed by add $7,$0,$3 -> no stall. lw $5 followed by bne $5,$6 -> no stall. lw $5 followed by sw $5,0($2) -> no stall.
- Mul: mul in D/X, RDY at cycle 33 after start -> ctrl_MULT one cycle at T; freeze T..T+32; md_take=1, md_error=0 at T+33; md_busy 0 at T+34.
- Div-by-zero: div in D/X, RDY with md_exception=1 at T+5 -> md_take=md_error=1 at T+5.
- Timeout: div, RDY never asserted, MD_TIMEOUT=40 -> md_take=md_error=1 at T+40; IDLE at T+41.
- Reset at T+10 of BUSY -> IDLE, counters 0, no md_take. Back-to-back mul,mul -> second ctrl_MULT in the cycle after the first md_take.
